// File: rtl/tdm_pkg.sv
// tdm_pkg: shared channel index type and select-pair helpers for the
// tdm_mux4 transmit path.
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef logic [1:0] chan_t;

    // Select MSB carried on the output as out_s0.
    function automatic logic chan_s0(input chan_t c);
        return c[1];
    endfunction

    // Select LSB carried on the output as out_s1.
    function automatic logic chan_s1(input chan_t c);
        return c[0];
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: combinational round-robin grant over four requests, searching
// upward from ptr and wrapping 3 -> 0.
module rr_arb4
    import tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  chan_t             ptr,
    output chan_t             grant,
    output logic              any_req
);

    chan_t idx;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant   = ptr;
        idx     = ptr;
        any_req = |req;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            idx = ptr + chan_t'(i - 1);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/tdm_mux4.sv
// tdm_mux4: four-channel valid/ready time-division multiplexer. Each output
// beat carries its source channel as {out_s0,out_s1}.
// Build option TDM_MUX_FIXED_SLOT_EN: strict fixed-slot TDM (ptr is a slot
// counter) instead of the default round-robin arbitration.
module tdm_mux4
    import tdm_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_s0,
    output logic                     out_s1,
    input  logic                     out_ready
);

    chan_t ptr;
    chan_t sel;
    logic  load_ok;
    logic  accept;

    // The holding register can take a new beat when empty or draining.
    always_comb begin
        load_ok = !out_valid || out_ready;
    end

`ifdef TDM_MUX_FIXED_SLOT_EN
    // Only the channel owning the current slot is offered the register.
    always_comb begin
        sel      = ptr;
        accept   = rst_n && load_ok && in_valid[ptr];
        in_ready = '0;
        if (rst_n && load_ok) begin
            in_ready[ptr] = 1'b1;
        end
    end
`else
    logic any_req;

    rr_arb4 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .grant   (sel),
        .any_req (any_req)
    );

    // Granted channel sees ready whenever the register can load.
    always_comb begin
        accept   = rst_n && load_ok && any_req;
        in_ready = '0;
        if (accept) begin
            in_ready[sel] = 1'b1;
        end
    end
`endif

    // Holding register, valid drain and pointer/slot update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_s0    <= 1'b0;
            out_s1    <= 1'b0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[sel*DATA_W +: DATA_W];
                out_s0    <= chan_s0(sel);
                out_s1    <= chan_s1(sel);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef TDM_MUX_FIXED_SLOT_EN
            if (load_ok) begin
                ptr <= ptr + 2'd1;
            end
`else
            if (accept) begin
                ptr <= sel + 2'd1;
            end
`endif
        end
    end

endmodule

// File: doc/tdm_mux4.md
# tdm_mux4

Four-channel time-division multiplexer with valid/ready handshakes on every port. It is the transmit end of the 1-to-4 select/demux path: it merges four independent channel streams onto one output stream. Each output beat carries its source channel as the {s0,s1} select pair, so a downstream 1-to-4 demux can route the beat back to the matching output. Arbitration is round-robin by default; a strict fixed-slot TDM mode is available at compile time.

## Interface
- DATA_W, default 1: width of each channel's data word.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  4  per-channel valid; bit c belongs to channel c.
- in_data  input  4*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- in_ready  output  4  per-channel ready; at most one bit is high in any cycle.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  registered data of the beat.
- out_s0  output  1  channel select MSB; channel index = {out_s0,out_s1}.
- out_s1  output  1  channel select LSB.
- out_ready  input  1  downstream ready.

## Operation
- Single output holding register (out_valid, out_data, out_s0, out_s1) plus a 2-bit priority pointer ptr.
- load_ok = !out_valid || out_ready.
- Round-robin (default):
  - grant = first c with in_valid[c] set, searching c = ptr, ptr+1, … mod 4.
  - in_ready[grant] = load_ok when any in_valid bit is set; all other in_ready bits are 0.
  - When in_valid[grant] && in_ready[grant]: the register loads in_data of channel grant, {out_s0,out_s1} = grant, out_valid = 1, and ptr = grant+1 mod 4.
- No load while out_valid && out_ready: out_valid falls to 0. out_data, out_s0 and out_s1 keep their values.
- Output hold: while out_valid && !out_ready, all four output fields are stable and in_ready = 0.
- in_ready depends combinationally on in_valid, ptr, out_valid and out_ready. A source must not make in_valid depend on in_ready.
- Pointer wrap: 3 → 0. ptr changes only on an accepted beat.
- Simultaneous drain and load (out_valid && out_ready && new accept) gives back-to-back beats with no bubble.

## Timing
- Reset (rst_n = 0 sampled at a clk edge): out_valid = 0, out_data = 0, out_s0 = 0, out_s1 = 0, ptr = 0. in_ready is 0 in that cycle.
- Reset asserted mid-transfer: the pending output beat is discarded and no partial state is kept.
- Latency: 1 cycle from the accepting edge to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high.
- Fairness: with all four channels valid continuously, grants go 0,1,2,3,0,…
- Any channel waits at most 3 granted beats.

## Configuration
- TDM_MUX_FIXED_SLOT_EN defined: strict TDM mode. ptr acts as a slot counter.
  - in_ready[ptr] = load_ok; all other in_ready bits are 0.
  - ptr advances every cycle in which load_ok is true, whether or not in_valid[ptr] is set.
  - An empty slot produces no beat: out_valid goes to 0 if it drained. Channel position is fixed in time.
- TDM_MUX_FIXED_SLOT_EN not defined: round-robin as described under Operation.
- Reset values and the output hold rule are the same in both modes.

## Structure
- Package tdm_pkg holds:
  - NUM_CH = 4;
  - chan_t, a 2-bit channel index typedef;
  - functions to split chan_t into s0 (bit 1) and s1 (bit 0).
- Sub-module rr_arb4: combinational round-robin grant from a 4-bit request vector and ptr. Outputs are grant (chan_t) and any_req. tdm_mux4 instantiates it only when TDM_MUX_FIXED_SLOT_EN is not defined.
- Top level contains the holding register, the ptr update and the handshake logic.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with all in_valid = 1. Required: out_valid = 0, out_data = 0, out_s0 = out_s1 = 0, in_ready = 0. On release, the first grant is channel 0.
- Full load, DATA_W = 4: channel data = 4'hA, 4'hB, 4'hC, 4'hD, all valid, out_ready = 1. Required: outputs A,B,C,D repeating, {s0,s1} = 00,01,10,11, one beat per cycle.
- Sparse: only channel 2 valid, data 4'h5. Required: every beat has out_data = 5 and {s0,s1} = 10; ptr settles at 3.
- Backpressure: out_ready = 0 for 5 cycles during traffic. Required: the output is frozen and in_ready = 0. After out_ready rises, the next grant follows the stalled channel.
- Mid-stream reset: a beat is pending on channel 1 and rst_n drops for 1 cycle. Required: out_valid = 0 next cycle and ptr = 0; the channel 1 beat is not re-emitted unless it is re-presented.
- TDM_MUX_FIXED_SLOT_EN build: only channels 0 and 3 valid. Required: beats appear in cycles 0 and 3 of every 4, and out_valid = 0 in slot cycles 1 and 2.
